hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 34 +++
 rtl/hazard_ctrl_sat_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, control bundle and
// the NOP instruction used when the pipeline inserts a bubble or flush.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } hz_state_e;

  // RV32I canonical NOP: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Wide enough for the largest supported memory wait limit (255).
  localparam int WAIT_W = 8;

  typedef struct packed {
    logic pipe_freeze;
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_bubble;
    logic if_id_flush;
  } hz_ctrl_t;

  function automatic hz_ctrl_t freeze_ctrl();
    hz_ctrl_t c;
    c             = '0;
    c.pipe_freeze = 1'b1;
    c.pc_stall    = 1'b1;
    c.if_id_stall = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// whole-pipeline freeze on data-memory waits with timeout into an error state.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_RegWEn,
  input  logic             ex_MemRead,
  input  logic             ex_BrTaken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             err_clr,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  hz_ctrl_t          ctrl;
  logic              load_use;
  logic              mem_stall;

  assign load_use = ex_MemRead && ex_RegWEn && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  // A request acknowledged in the same cycle completes without freezing.
  assign mem_stall = mem_req && !mem_ack;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ctrl       = '0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          ctrl       = freeze_ctrl();
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else if (ex_BrTaken) begin
          // Branch flush wins over load-use: the stalled instruction is wrong-path.
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end else if (load_use) begin
          ctrl.pc_stall     = 1'b1;
          ctrl.if_id_stall  = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        ctrl = freeze_ctrl();
        if (mem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIM) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ST_ERR: begin
        ctrl = freeze_ctrl();
        if (err_clr) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end

      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Controls must be quiet while reset is held, even mid-wait.
    if (rst) ctrl = '0;
  end

  assign mem_err_d = (state_d == ST_ERR);

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign if_id_flush  = ctrl.if_id_flush;
  assign pipe_freeze  = ctrl.pipe_freeze;
  assign mem_err      = mem_err_q;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.pc_stall),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl; a default instance and a
// 4-bit-counter instance share stimulus and are checked against one model.
module tb_hazard_ctrl;

  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_RegWEn, ex_MemRead, ex_BrTaken;
  logic       mem_req, mem_ack, err_clr;

  logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_freeze, mem_err;
  logic [15:0] stall_cnt;
  logic        c4_pc_stall, c4_if_id_stall, c4_id_ex_bubble, c4_if_id_flush, c4_pipe_freeze;
  logic        c4_mem_err;
  logic [3:0]  c4_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: abstract description of the memory wait episode.
  bit m_waiting;
  bit m_err;
  int m_waited;
  int m_cnt;
  int m_cnt4;

  always #5 clk = ~clk;

  hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_RegWEn(ex_RegWEn), .ex_MemRead(ex_MemRead), .ex_BrTaken(ex_BrTaken),
    .mem_req(mem_req), .mem_ack(mem_ack), .err_clr(err_clr),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .pipe_freeze(pipe_freeze), .mem_err(mem_err),
    .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_RegWEn(ex_RegWEn), .ex_MemRead(ex_MemRead), .ex_BrTaken(ex_BrTaken),
    .mem_req(mem_req), .mem_ack(mem_ack), .err_clr(err_clr),
    .pc_stall(c4_pc_stall), .if_id_stall(c4_if_id_stall), .id_ex_bubble(c4_id_ex_bubble),
    .if_id_flush(c4_if_id_flush), .pipe_freeze(c4_pipe_freeze), .mem_err(c4_mem_err),
    .stall_cnt(c4_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_load_use();
    return ex_MemRead && ex_RegWEn && (ex_rd != 5'd0) &&
           ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
  endfunction

  // Expected {pipe_freeze, pc_stall, if_id_stall, id_ex_bubble, if_id_flush}.
  function automatic logic [4:0] model_ctrl();
    if (rst) return 5'b00000;
    if (m_err || m_waiting || (mem_req && !mem_ack)) return 5'b11100;
    if (ex_BrTaken) return 5'b00011;
    if (model_load_use()) return 5'b01110;
    return 5'b00000;
  endfunction

  function automatic logic [4:0] ctrl_main();
    return {pipe_freeze, pc_stall, if_id_stall, id_ex_bubble, if_id_flush};
  endfunction

  function automatic logic [4:0] ctrl_c4();
    return {c4_pipe_freeze, c4_pc_stall, c4_if_id_stall, c4_id_ex_bubble, c4_if_id_flush};
  endfunction

  task automatic model_clear();
    m_waiting = 1'b0;
    m_err     = 1'b0;
    m_waited  = 0;
    m_cnt     = 0;
    m_cnt4    = 0;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_RegWEn = 1'b0; ex_MemRead = 1'b0;
    ex_BrTaken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0; err_clr = 1'b0;
  endtask

  // Called at a falling edge with inputs applied; checks, then crosses one rising edge.
  task automatic tick();
    logic [4:0] e;
    e = model_ctrl();
    #1;
    check("ctrl", 32'(ctrl_main()), 32'(e));
    check("c4_ctrl", 32'(ctrl_c4()), 32'(e));
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    check("c4_stall_cnt", 32'(c4_stall_cnt), 32'(m_cnt4));
    @(posedge clk);
    if (!rst) begin
      if (e[3]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (m_err) begin
        if (err_clr) begin m_err = 1'b0; m_waited = 0; end
      end else if (m_waiting) begin
        if (mem_ack) m_waiting = 1'b0;
        else if (m_waited == WAIT_MAX) begin m_waiting = 1'b0; m_err = 1'b1; end
        else m_waited++;
      end else if (mem_req && !mem_ack) begin
        m_waiting = 1'b1;
        m_waited  = 1;
      end
    end
    @(negedge clk);
  endtask

  // Asserts reset at a falling edge (asynchronously), checks quiet outputs, releases.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ctrl", 32'(ctrl_main()), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_c4_stall_cnt", 32'(c4_stall_cnt), 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_MemRead = 1'b1; ex_RegWEn = 1'b1; ex_rd = rd;
    id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  task automatic random_cycles(input int n, input int ack_pct);
    for (int i = 0; i < n; i++) begin
      id_rs1     = 5'($urandom_range(0, 7));
      id_rs2     = 5'($urandom_range(0, 7));
      ex_rd      = 5'($urandom_range(0, 7));
      id_use_rs1 = ($urandom_range(0, 99) < 60);
      id_use_rs2 = ($urandom_range(0, 99) < 60);
      ex_RegWEn  = ($urandom_range(0, 99) < 70);
      ex_MemRead = ($urandom_range(0, 99) < 50);
      ex_BrTaken = ($urandom_range(0, 99) < 15);
      mem_req    = ($urandom_range(0, 99) < 25);
      mem_ack    = ($urandom_range(0, 99) < ack_pct);
      err_clr    = ($urandom_range(0, 99) < 20);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_clear();
    @(negedge clk);
    do_reset();

    // Single load-use stall, then the counter shows one stalled cycle.
    set_load_use(5'd5);
    tick();
    idle_inputs();
    tick();
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // rd == x0 never stalls; a taken branch overrides the load-use.
    set_load_use(5'd0);
    tick();
    set_load_use(5'd5);
    ex_BrTaken = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("br_stall_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait of three cycles, acknowledged on the fourth.
    do_reset();
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mem_ack = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("wait_stall_cnt", 32'(stall_cnt), 32'd4);

    // Timeout: mem_err appears in the 17th cycle after the request.
    do_reset();
    mem_req = 1'b1;
    for (int i = 1; i <= 16; i++) tick();
    #1;
    check("timeout_mem_err", 32'(mem_err), 32'd1);
    mem_req = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check("cleared_mem_err", 32'(mem_err), 32'd0);

    // Reset in the middle of a memory wait discards it.
    mem_req = 1'b1;
    tick();
    tick();
    do_reset();
    mem_req = 1'b0;
    tick();
    check("post_rst_freeze", 32'(pipe_freeze), 32'd0);

    // Saturation of the 4-bit statistics counter.
    do_reset();
    set_load_use(5'd5);
    for (int i = 0; i < 20; i++) tick();
    idle_inputs();
    check("sat_c4_stall_cnt", 32'(c4_stall_cnt), 32'd15);
    check("sat_stall_cnt", 32'(stall_cnt), 32'd20);

    // Randomized traffic: frequent acks, then rare acks to reach timeouts.
    do_reset();
    random_cycles(600, 50);
    random_cycles(400, 4);
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
